// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: word-organised unified instruction/data memory with a
// programmable wait-state handshake. One access is in flight at a time.
// Completion is signalled by a one-cycle ready pulse. Misaligned and
// out-of-range addresses raise err in place of the access.
module unified_mem_ctrl #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adrs,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Request captured at accept; later input changes are ignored.
    logic [31:0]   adrs_q;
    logic [31:0]   wdata_q;
    logic          wr_q;

    logic [31:0]   mem [DEPTH];

    logic          req_one;
    logic          req_both;
    logic          addr_bad;
    logic          access;
    logic          do_write;
    logic [AW-1:0] idx;

    assign req_one  = mem_read ^ mem_write;
    assign req_both = mem_read & mem_write;
    assign idx      = adrs_q[AW+1:2];
    // Faults are checked on the latched address so they stay stable while waiting.
    assign addr_bad = (adrs_q[1:0] != 2'b00) || (|adrs_q[31:AW+2]);
    assign access   = (state == WAIT) && (cnt == '0);
    assign do_write = access && wr_q && !addr_bad;

    // Capture address, store data and operation when a single request is accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_one) begin
            adrs_q  <= adrs;
            wdata_q <= wdata;
            wr_q    <= mem_write;
        end
    end

    // Memory array: written only on the access edge of a non-faulted write.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= wdata_q;
        end
    end

    // Handshake FSM with registered ready/err/busy/rdata outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_both) begin
                        // Conflicting request: fault immediately, no wait states.
                        state <= RESP;
                        busy  <= 1'b1;
                        ready <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                    end else if (req_one) begin
                        state <= WAIT;
                        busy  <= 1'b1;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= addr_bad;
                        if (!wr_q) begin
                            rdata <= addr_bad ? 32'h0 : mem[idx];
                        end
                    end
                end
                RESP: begin
                    // No accept on this edge, so a held request restarts one edge later.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: an edge-counting transaction model for the main
// instance, plus two extra instances (LATENCY 1 and 5) for the latency sweep.
module tb_unified_mem_ctrl;
    localparam int DEPTH = 1024;
    localparam int L     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adrs = '0;
    logic [31:0] wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    logic [31:0] s_adrs = 32'h40;
    logic [31:0] s_wdata = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s1_rdata, s5_rdata;
    logic        s1_ready, s5_ready, s1_busy, s5_busy, s1_err, s5_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    unified_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .adrs(adrs), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    unified_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .adrs(s_adrs), .wdata(s_wdata),
        .mem_read(s_read), .mem_write(s_write),
        .rdata(s1_rdata), .ready(s1_ready), .busy(s1_busy), .err(s1_err)
    );

    unified_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(5)) u_l5 (
        .clk(clk), .rst(rst), .adrs(s_adrs), .wdata(s_wdata),
        .mem_read(s_read), .mem_write(s_write),
        .rdata(s5_rdata), .ready(s5_ready), .busy(s5_busy), .err(s5_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // Edges are numbered; an access accepted at edge a completes at edge a+L,
    // keeps busy high for samples a..a+L and allows the next accept at a+L+2.
    int          cyc = 0;
    int          done_at = -1;
    int          free_at = 0;
    int          busy_end = -1;
    bit          pend = 1'b0;
    bit          p_wr = 1'b0;
    logic [31:0] p_adr = '0;
    logic [31:0] p_wd = '0;
    logic [31:0] mmem [DEPTH];
    logic [31:0] e_rdata = '0;
    bit          e_ready = 1'b0;
    bit          e_err = 1'b0;

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= DEPTH * 4);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend = 1'b0; busy_end = -1; free_at = 0;
            e_ready = 1'b0; e_err = 1'b0; e_rdata = '0;
        end else begin
            cyc++;
            e_ready = 1'b0;
            e_err = 1'b0;
            if (pend && cyc == done_at) begin
                pend = 1'b0;
                e_ready = 1'b1;
                e_err = addr_bad(p_adr);
                if (p_wr) begin
                    if (!e_err) mmem[p_adr / 4] = p_wd;
                end else begin
                    e_rdata = e_err ? 32'h0 : mmem[p_adr / 4];
                end
            end else if (!pend && cyc >= free_at && (mem_read || mem_write)) begin
                if (mem_read && mem_write) begin
                    e_ready = 1'b1; e_err = 1'b1; e_rdata = '0;
                    busy_end = cyc; free_at = cyc + 2;
                end else begin
                    pend = 1'b1; p_wr = mem_write; p_adr = adrs; p_wd = wdata;
                    done_at = cyc + L; busy_end = cyc + L; free_at = cyc + L + 2;
                end
            end
        end
    end

    // Compare every cycle once the bench has applied its first reset.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'h0, ready}, {31'h0, e_ready});
            chk("err",   {31'h0, err},   {31'h0, e_err});
            chk("busy",  {31'h0, busy},  {31'h0, (cyc <= busy_end)});
            chk("rdata", rdata, e_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output int waited, output logic r_err, output logic [31:0] r_data);
        @(negedge clk);
        mem_read = rd; mem_write = wr; adrs = a; wdata = d;
        waited = 0; r_err = 1'b0; r_data = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            waited++;
            if (ready) begin
                r_err = err; r_data = rdata;
                break;
            end
        end
        if (!ready) begin
            total++; bad++;
            $display("FAIL access_timeout: no ready for adrs %h", a);
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            waited++;
            if (ready) break;
        end
    endtask

    task automatic sweep(input bit wr, input logic [31:0] d,
                         output int lat1, output int lat5, output int b1, output int b5,
                         output logic [31:0] rd1, output logic [31:0] rd5, output int e_cnt);
        @(negedge clk);
        s_read = !wr; s_write = wr; s_wdata = d;
        @(posedge clk);
        @(negedge clk);
        s_read = 1'b0; s_write = 1'b0;
        lat1 = -1; lat5 = -1; b1 = 0; b5 = 0; rd1 = '0; rd5 = '0; e_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (s1_busy) b1++;
            if (s5_busy) b5++;
            if (s1_ready && lat1 < 0) begin lat1 = k; rd1 = s1_rdata; end
            if (s5_ready && lat5 < 0) begin lat5 = k; rd5 = s5_rdata; end
            if (s1_err || s5_err) e_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int w, w2, spurious, l1, l5, b1, b5, ec;
        logic e;
        logic [31:0] d, r1, r5;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);

        // Write then read back.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, w, e, d);
        chk("wr_wait_cycles", w, 3);
        chk("wr_err", {31'h0, e}, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0, w, e, d);
        chk("rd_data", d, 32'hDEADBEEF);

        // Misaligned write is dropped and flagged.
        access(1'b0, 1'b1, 32'h12, 32'h55555555, w, e, d);
        chk("misalign_err", {31'h0, e}, 32'h1);
        access(1'b1, 1'b0, 32'h10, 32'h0, w, e, d);
        chk("misalign_keep", d, 32'hDEADBEEF);

        // Out-of-range read.
        access(1'b1, 1'b0, 32'h0001_0000, 32'h0, w, e, d);
        chk("oor_err", {31'h0, e}, 32'h1);
        chk("oor_rdata", d, 32'h0);

        // Dual request: immediate fault, memory untouched.
        access(1'b1, 1'b1, 32'h10, 32'h12345678, w, e, d);
        chk("dual_wait", w, 1);
        chk("dual_err", {31'h0, e}, 32'h1);
        access(1'b1, 1'b0, 32'h10, 32'h0, w, e, d);
        chk("dual_keep", d, 32'hDEADBEEF);

        // Request held through RESP restarts two edges after ready.
        @(negedge clk);
        mem_read = 1'b1; adrs = 32'h10;
        wait_ready(w);
        wait_ready(w2);
        chk("held_gap", w2, L + 2);
        mem_read = 1'b0;

        // Inputs changed after accept must not affect the access.
        access(1'b0, 1'b1, 32'h34, 32'hAAAA0000, w, e, d);
        @(negedge clk);
        mem_write = 1'b1; adrs = 32'h30; wdata = 32'h11112222;
        @(negedge clk);
        adrs = 32'h34; wdata = 32'hFFFFFFFF;
        wait_ready(w);
        mem_write = 1'b0;
        access(1'b1, 1'b0, 32'h30, 32'h0, w, e, d);
        chk("latched_wr", d, 32'h11112222);
        access(1'b1, 1'b0, 32'h34, 32'h0, w, e, d);
        chk("other_word", d, 32'hAAAA0000);

        // Reset during WAIT of a write aborts it.
        access(1'b0, 1'b1, 32'h20, 32'h0BADF00D, w, e, d);
        @(negedge clk);
        mem_write = 1'b1; adrs = 32'h20; wdata = 32'h12345678;
        @(negedge clk);
        #1 rst = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        spurious = 0;
        repeat (3) begin @(negedge clk); if (ready) spurious++; end
        rst = 1'b1;
        repeat (4) begin @(negedge clk); if (ready) spurious++; end
        chk("rst_no_ready", spurious, 0);
        access(1'b1, 1'b0, 32'h20, 32'h0, w, e, d);
        chk("rst_old_data", d, 32'h0BADF00D);

        // Latency sweep on the LATENCY=1 and LATENCY=5 instances.
        sweep(1'b1, 32'hCAFEF00D, l1, l5, b1, b5, r1, r5, ec);
        chk("lat1", l1, 1);
        chk("lat5", l5, 5);
        chk("busy1", b1, 2);
        chk("busy5", b5, 6);
        sweep(1'b0, 32'h0, l1, l5, b1, b5, r1, r5, ec);
        chk("lat1_rd", l1, 1);
        chk("lat5_rd", l5, 5);
        chk("rd1", r1, 32'hCAFEF00D);
        chk("rd5", r5, 32'hCAFEF00D);
        chk("sweep_err", ec, 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/unified_mem_ctrl.md
# unified_mem_ctrl

Word-organised unified instruction/data memory with a wait-state handshake, placed directly beneath the multi-cycle MIPS core. It serves instruction fetches and load/store accesses on one port. It inserts a programmable number of wait states and returns each access with a one-cycle `ready` pulse. Misaligned and out-of-range accesses are flagged rather than silently aliased.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: wait cycles between accept and access; ≥ 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `adrs` input 32: byte address; word index = `adrs[log2(DEPTH)+1:2]`.
- `wdata` input 32: store data.
- `mem_read` input 1: read request level.
- `mem_write` input 1: write request level.
- `rdata` output 32: registered read data.
- `ready` output 1: one-cycle completion pulse.
- `busy` output 1: high while an access is in flight (WAIT or RESP).
- `err` output 1: one-cycle pulse, co-timed with `ready`, for a faulted access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, `mem_read` xor `mem_write` at an edge:
  - Accept the request.
  - Latch `adrs`, `wdata` and op.
  - Load `cnt` = LATENCY−1.
  - Go to WAIT.
- IDLE, `mem_read` and `mem_write` both high:
  - Request is illegal.
  - Go to RESP with fault set and no access.
  - `rdata` is forced to 0.
- IDLE, no request: stay in IDLE.
- WAIT:
  - If `cnt` ≠ 0, decrement it.
  - If `cnt` = 0, perform the access at this edge and go to RESP.
- RESP: `ready` = 1 and `err` = fault flag; next edge goes to IDLE. No request is accepted on the RESP→IDLE edge.
- Read access: `rdata` ← `mem[index]`. `rdata` holds that value until the next completed read or fault.
- Write access: `mem[index]` ← latched `wdata`. `rdata` is unchanged.
- Fault conditions, checked on the latched address:
  - `adrs[1:0]` ≠ 0 (misaligned).
  - Any bit of `adrs[31:log2(DEPTH)+2]` set (out of range).
- Fault behaviour:
  - Write is dropped.
  - Read returns `rdata` = 0.
  - `err` pulses together with `ready`.
- Request inputs are ignored outside IDLE. Changes to `adrs`, `wdata` or op after accept have no effect.
- The requester holds its request until it sees `ready`, then deasserts in that same cycle or else a second access starts.

## Timing
- Accept edge E0.
  - `busy` rises after E0.
  - Access happens at edge E0+LATENCY.
  - `ready` and `err` are high for exactly one cycle, between E0+LATENCY and E0+LATENCY+1.
- Read data is valid in the `ready` cycle.
- Write data is visible to a read accepted at any later edge.
- Illegal dual request: `ready` and `err` are high in the cycle after E0; no wait states.
- Throughput: one access per LATENCY+2 cycles.
- Reset values, asserted asynchronously:
  - State IDLE, `cnt` 0, `busy` 0.
  - `ready` 0, `err` 0, `rdata` 0.
  - Memory array is not cleared.
- Reset during WAIT aborts the access: no write occurs and no `ready` is issued.
- Reset during RESP suppresses the remainder of the pulse immediately.
- The first edge after reset release can accept a request.

## Test plan
- Write then read, LATENCY=2:
  - Write `0x0000_0010`, `0xDEADBEEF`: accept at E0, `ready` high in cycle E2–E3, `err` 0.
  - Read back the same address: `rdata` = `0xDEADBEEF` in its `ready` cycle.
- LATENCY=1 and LATENCY=5 sweep: measure cycles from accept to `ready`; must equal LATENCY exactly; `busy` high for LATENCY+1 cycles.
- Misaligned and out-of-range faults:
  - Write `0x0000_0012`: `err` and `ready` pulse together; a later read of word 4 is unchanged.
  - Read `0x0001_0000` with DEPTH=1024: `rdata` = 0, `err` = 1.
- Illegal and held requests:
  - `mem_read` and `mem_write` high together: `ready` and `err` next cycle, memory untouched.
  - Request held through RESP: re-accepted at the second edge after `ready`.
- Input changes after accept: change `adrs` and `wdata` during WAIT; the access uses the values latched at E0.
- Reset mid-access: deassert `rst` (drive low) during WAIT of a write to `0x20`.
  - All outputs read 0.
  - A subsequent read of `0x20` returns the old content.
  - No spurious `ready` is issued.
